// File: rtl/frost32_mem_bridge_pkg.sv
// -----------------------------------------------------------------------------
// frost32_mem_bridge_pkg
//
// Shared types for the Frost32 data-port memory bridge:
//   - DataInoutAccessType : read / write selector driven by the CPU
//   - DataInoutAccessSize : 32 / 16 / 8-bit access size (3 is invalid)
//   - MemBridgeState      : bridge FSM states
//   - get_num_bytes()     : byte count for an access size
//   - is_bad_request()    : size / alignment rejection rule
// -----------------------------------------------------------------------------
`ifndef MSB_POS__FROST32_MEM_BRIDGE_STATE
`define MSB_POS__FROST32_MEM_BRIDGE_STATE 1
`endif

package frost32_mem_bridge_pkg;

  typedef enum logic {
    DiatRead  = 1'b0,
    DiatWrite = 1'b1
  } DataInoutAccessType;

  typedef enum logic [1:0] {
    DiaSz32  = 2'd0,
    DiaSz16  = 2'd1,
    DiaSz8   = 2'd2,
    DiaSzBad = 2'd3
  } DataInoutAccessSize;

  typedef enum logic [`MSB_POS__FROST32_MEM_BRIDGE_STATE:0] {
    StIdle,
    StXfer,
    StDrain,
    StAck
  } MemBridgeState;

  // Number of byte beats needed for one access; zero for the invalid size.
  function automatic logic [2:0] get_num_bytes(DataInoutAccessSize size);
    logic [2:0] count;
    case (size)
      DiaSz32: count = 3'd4;
      DiaSz16: count = 3'd2;
      DiaSz8:  count = 3'd1;
      default: count = 3'd0;
    endcase
    return count;
  endfunction

  // A request is rejected for the invalid size, or when a halfword is not on
  // an even address, or a word is not on a multiple-of-four address.
  function automatic logic is_bad_request(DataInoutAccessSize size,
                                          logic [1:0] addrLsbs);
    logic bad;
    case (size)
      DiaSz32: bad = (addrLsbs != 2'b00);
      DiaSz16: bad = addrLsbs[0];
      DiaSz8:  bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/frost32_mem_bridge_if.sv
// -----------------------------------------------------------------------------
// frost32_mem_bridge_if
//
// CPU data-port <-> memory bridge request/response bundle.
//   req_mem_access          CPU -> bridge  request strobe
//   data_inout_access_type  CPU -> bridge  read / write
//   data_inout_access_size  CPU -> bridge  32 / 16 / 8-bit
//   addr                    CPU -> bridge  byte address
//   wr_data                 CPU -> bridge  write data (little-endian bytes)
//   rd_data                 bridge -> CPU  assembled read word
//   mem_ack                 bridge -> CPU  one-cycle completion pulse
//   mem_err                 bridge -> CPU  rejection flag, valid with mem_ack
// Modports: master (CPU side), slave (bridge side).
// -----------------------------------------------------------------------------
interface frost32_mem_bridge_if;
  import frost32_mem_bridge_pkg::*;

  logic               req_mem_access;
  DataInoutAccessType data_inout_access_type;
  DataInoutAccessSize data_inout_access_size;
  logic [31:0]        addr;
  logic [31:0]        wr_data;
  logic [31:0]        rd_data;
  logic               mem_ack;
  logic               mem_err;

  modport master (
    output req_mem_access,
    output data_inout_access_type,
    output data_inout_access_size,
    output addr,
    output wr_data,
    input  rd_data,
    input  mem_ack,
    input  mem_err
  );

  modport slave (
    input  req_mem_access,
    input  data_inout_access_type,
    input  data_inout_access_size,
    input  addr,
    input  wr_data,
    output rd_data,
    output mem_ack,
    output mem_err
  );

endinterface

// File: rtl/frost32_mem_bridge_byte_ram.sv
// -----------------------------------------------------------------------------
// frost32_byte_ram
//
// Single-port byte-wide RAM with a registered (one-cycle) read.
//   clk        clock
//   we_i       write enable for addr_i
//   addr_i     byte address
//   wr_data_i  byte to write
//   rd_data_o  byte at the address presented on the previous cycle
// Contents are intentionally not reset.
// -----------------------------------------------------------------------------
module frost32_byte_ram
  import frost32_mem_bridge_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      we_i,
  input  logic [RAM_ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]                wr_data_i,
  output logic [7:0]                rd_data_o
);

  logic [7:0] mem_q [2**RAM_ADDR_WIDTH];

  // Storage write and read-old-data output register share one edge so the
  // read path maps onto a plain synchronous block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wr_data_i;
    end
    rd_data_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/frost32_mem_bridge.sv
// -----------------------------------------------------------------------------
// frost32_mem_bridge
//
// Turns one Frost32 data-port request into a sequence of byte accesses on an
// internal byte-wide RAM and reports completion with a one-cycle mem_ack.
//   clk   clock, all state on the rising edge
//   rst   synchronous active-high reset
//   bus   frost32_mem_bridge_if.slave request/response bundle
// Parameter RAM_ADDR_WIDTH sets the RAM depth (2**RAM_ADDR_WIDTH bytes);
// higher address bits alias.
// -----------------------------------------------------------------------------
module frost32_mem_bridge
  import frost32_mem_bridge_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  frost32_mem_bridge_if.slave  bus
);

  MemBridgeState             state_q,    state_d;
  logic [1:0]                byteCnt_q,  byteCnt_d;
  logic [RAM_ADDR_WIDTH-1:0] addr_q,     addr_d;
  DataInoutAccessType        accType_q,  accType_d;
  DataInoutAccessSize        accSize_q,  accSize_d;
  logic [31:0]               wrData_q,   wrData_d;
  logic                      err_q,      err_d;
  logic [31:0]               assembly_q, assembly_d;
  logic [31:0]               rdData_q,   rdData_d;

  logic [2:0]                numBytes;
  logic [1:0]                lastIdx;
  logic [1:0]                prevIdx;
  logic [31:0]               drainedWord;
  logic                      ramWe;
  logic [RAM_ADDR_WIDTH-1:0] ramAddr;
  logic [7:0]                ramWrData;
  logic [7:0]                ramRdData;
  logic                      unusedAddrBits;

  // Address bits above the RAM width are dropped on purpose (aliasing).
  assign unusedAddrBits = ^bus.addr[31:RAM_ADDR_WIDTH];

  assign numBytes = get_num_bytes(accSize_q);
  assign lastIdx  = 2'(numBytes - 3'd1);
  // The RAM output seen during beat i belongs to beat i-1.
  assign prevIdx  = byteCnt_q - 2'd1;

  // RAM address wraps naturally at the RAM width.
  assign ramAddr   = addr_q + RAM_ADDR_WIDTH'(byteCnt_q);
  assign ramWrData = wrData_q[8*byteCnt_q +: 8];
  assign ramWe     = (state_q == StXfer) && (accType_q == DiatWrite);

  // Final read word: everything collected so far plus the last byte, which
  // only shows up on the RAM output during StDrain. Upper bytes of narrow
  // reads stay zero because the assembly register is cleared on accept.
  always_comb begin
    drainedWord = assembly_q;
    drainedWord[8*lastIdx +: 8] = ramRdData;
  end

  // Next-state and datapath logic for the whole bridge.
  always_comb begin
    state_d    = state_q;
    byteCnt_d  = byteCnt_q;
    addr_d     = addr_q;
    accType_d  = accType_q;
    accSize_d  = accSize_q;
    wrData_d   = wrData_q;
    err_d      = err_q;
    assembly_d = assembly_q;
    rdData_d   = rdData_q;

    case (state_q)
      StIdle: begin
        if (bus.req_mem_access) begin
          addr_d     = bus.addr[RAM_ADDR_WIDTH-1:0];
          accType_d  = bus.data_inout_access_type;
          accSize_d  = bus.data_inout_access_size;
          wrData_d   = bus.wr_data;
          byteCnt_d  = 2'd0;
          assembly_d = 32'd0;
          if (is_bad_request(bus.data_inout_access_size, bus.addr[1:0])) begin
            err_d   = 1'b1;
            state_d = StAck;
          end else begin
            err_d   = 1'b0;
            state_d = StXfer;
          end
        end
      end

      StXfer: begin
        if (byteCnt_q != 2'd0) begin
          assembly_d[8*prevIdx +: 8] = ramRdData;
        end
        if (byteCnt_q == lastIdx) begin
          state_d = (accType_q == DiatWrite) ? StAck : StDrain;
        end else begin
          byteCnt_d = byteCnt_q + 2'd1;
        end
      end

      StDrain: begin
        rdData_d = drainedWord;
        state_d  = StAck;
      end

      StAck: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset clears everything except the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      byteCnt_q  <= 2'd0;
      addr_q     <= '0;
      accType_q  <= DiatRead;
      accSize_q  <= DiaSz32;
      wrData_q   <= 32'd0;
      err_q      <= 1'b0;
      assembly_q <= 32'd0;
      rdData_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      byteCnt_q  <= byteCnt_d;
      addr_q     <= addr_d;
      accType_q  <= accType_d;
      accSize_q  <= accSize_d;
      wrData_q   <= wrData_d;
      err_q      <= err_d;
      assembly_q <= assembly_d;
      rdData_q   <= rdData_d;
    end
  end

  assign bus.rd_data = rdData_q;
  assign bus.mem_ack = (state_q == StAck);
  assign bus.mem_err = (state_q == StAck) && err_q;

  frost32_byte_ram #(
    .RAM_ADDR_WIDTH(RAM_ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .we_i      (ramWe),
    .addr_i    (ramAddr),
    .wr_data_i (ramWrData),
    .rd_data_o (ramRdData)
  );

endmodule

// File: tb/tb_frost32_mem_bridge.sv
// -----------------------------------------------------------------------------
// tb_frost32_mem_bridge
//
// Directed, table-driven bench for frost32_mem_bridge with hand-computed
// expected latencies, error flags and read data, followed by hand-written
// sequences for mid-access reset and back-to-back requests.
// -----------------------------------------------------------------------------
module tb_frost32_mem_bridge;
  import frost32_mem_bridge_pkg::*;

  localparam int         MAX_WAIT = 20;
  localparam int         NUM_VECS = 19;
  localparam logic       WR   = 1'b1;
  localparam logic       RD   = 1'b0;
  localparam logic [1:0] SZ32 = 2'd0;
  localparam logic [1:0] SZ16 = 2'd1;
  localparam logic [1:0] SZ8  = 2'd2;
  localparam logic [1:0] SZX  = 2'd3;

  typedef struct packed {
    logic        isWrite;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  expLat;
    logic        expErr;
    logic [31:0] expRd;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs [NUM_VECS];

  frost32_mem_bridge_if bus ();

  frost32_mem_bridge #(
    .RAM_ADDR_WIDTH(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: bumps the check count and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Issue one request in the next cycle (cycle A), hold it until mem_ack and
  // report the ack cycle offset from A (0 when no ack arrived in time).
  task automatic applyStimulus(input logic isWrite, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output int lat, output logic [31:0] rd,
                               output logic err);
    lat = 0;
    rd  = 32'd0;
    err = 1'b0;
    @(posedge clk);
    #1;
    bus.req_mem_access         = 1'b1;
    bus.data_inout_access_type = isWrite ? DiatWrite : DiatRead;
    bus.data_inout_access_size = DataInoutAccessSize'(size);
    bus.addr                   = addr;
    bus.wr_data                = wdata;
    for (int k = 1; k <= MAX_WAIT; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.mem_ack) begin
        lat = k;
        rd  = bus.rd_data;
        err = bus.mem_err;
        break;
      end
    end
    bus.req_mem_access = 1'b0;
    if (lat != 0) begin
      @(negedge clk);
      checkOutput("ack single cycle", 32'(bus.mem_ack), 32'd0);
    end
  endtask

  int          lat;
  logic [31:0] rd;
  logic        err;

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{WR, SZ32, 32'h0000_0100, 32'hDEAD_BEEF, 4'd5, 1'b0, 32'h0000_0000};
    vecs[1]  = '{RD, SZ32, 32'h0000_0100, 32'h0000_0000, 4'd6, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{RD, SZ8,  32'h0000_0100, 32'h0000_0000, 4'd3, 1'b0, 32'h0000_00EF};
    vecs[3]  = '{RD, SZ8,  32'h0000_0103, 32'h0000_0000, 4'd3, 1'b0, 32'h0000_00DE};
    vecs[4]  = '{WR, SZ32, 32'h0000_0200, 32'h8765_4321, 4'd5, 1'b0, 32'h0000_00DE};
    vecs[5]  = '{WR, SZ16, 32'h0000_0202, 32'hAAAA_1234, 4'd3, 1'b0, 32'h0000_00DE};
    vecs[6]  = '{RD, SZ16, 32'h0000_0202, 32'h0000_0000, 4'd4, 1'b0, 32'h0000_1234};
    vecs[7]  = '{RD, SZ32, 32'h0000_0200, 32'h0000_0000, 4'd6, 1'b0, 32'h1234_4321};
    vecs[8]  = '{RD, SZ32, 32'h0000_0101, 32'h0000_0000, 4'd1, 1'b1, 32'h1234_4321};
    vecs[9]  = '{RD, SZ16, 32'h0000_0201, 32'h0000_0000, 4'd1, 1'b1, 32'h1234_4321};
    vecs[10] = '{WR, SZX,  32'h0000_0100, 32'hFFFF_FFFF, 4'd1, 1'b1, 32'h1234_4321};
    vecs[11] = '{WR, SZ32, 32'h0000_0102, 32'h0BAD_F00D, 4'd1, 1'b1, 32'h1234_4321};
    vecs[12] = '{RD, SZ32, 32'h0000_0100, 32'h0000_0000, 4'd6, 1'b0, 32'hDEAD_BEEF};
    vecs[13] = '{WR, SZ8,  32'h0001_0004, 32'h0000_005A, 4'd2, 1'b0, 32'hDEAD_BEEF};
    vecs[14] = '{RD, SZ8,  32'h0000_0004, 32'h0000_0000, 4'd3, 1'b0, 32'h0000_005A};
    vecs[15] = '{RD, SZ16, 32'h0000_0102, 32'h0000_0000, 4'd4, 1'b0, 32'h0000_DEAD};
    vecs[16] = '{RD, SZ32, 32'hFFFF_0100, 32'h0000_0000, 4'd6, 1'b0, 32'hDEAD_BEEF};
    vecs[17] = '{WR, SZ8,  32'h0000_0200, 32'hFFFF_FF99, 4'd2, 1'b0, 32'hDEAD_BEEF};
    vecs[18] = '{RD, SZ32, 32'h0000_0200, 32'h0000_0000, 4'd6, 1'b0, 32'h1234_4399};

    bus.req_mem_access         = 1'b0;
    bus.data_inout_access_type = DiatRead;
    bus.data_inout_access_size = DiaSz32;
    bus.addr                   = 32'd0;
    bus.wr_data                = 32'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset mem_ack", 32'(bus.mem_ack), 32'd0);
    checkOutput("reset mem_err", 32'(bus.mem_err), 32'd0);
    checkOutput("reset rd_data", bus.rd_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].isWrite, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                    lat, rd, err);
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].expLat));
      checkOutput($sformatf("vec%0d mem_err", i), 32'(err), 32'(vecs[i].expErr));
      checkOutput($sformatf("vec%0d rd_data", i), rd, vecs[i].expRd);
    end

    // Mid-access reset: preload 0x300..0x303, then reset during beat 2.
    applyStimulus(WR, SZ32, 32'h0000_0300, 32'hCAFE_F00D, lat, rd, err);
    checkOutput("preload latency", 32'(lat), 32'd5);
    @(posedge clk);
    #1;
    bus.req_mem_access         = 1'b1;
    bus.data_inout_access_type = DiatWrite;
    bus.data_inout_access_size = DiaSz32;
    bus.addr                   = 32'h0000_0300;
    bus.wr_data                = 32'h1122_3344;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_mem_access = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("post-reset no ack %0d", k), 32'(bus.mem_ack), 32'd0);
    end
    checkOutput("post-reset rd_data", bus.rd_data, 32'd0);
    applyStimulus(RD, SZ8, 32'h0000_0300, 32'd0, lat, rd, err);
    checkOutput("reset byte0 latency", 32'(lat), 32'd3);
    checkOutput("reset byte0 written", rd, 32'h0000_0044);
    applyStimulus(RD, SZ8, 32'h0000_0302, 32'd0, lat, rd, err);
    checkOutput("reset byte2 kept", rd, 32'h0000_00FE);
    applyStimulus(RD, SZ8, 32'h0000_0303, 32'd0, lat, rd, err);
    checkOutput("reset byte3 kept", rd, 32'h0000_00CA);

    // Back-to-back: request held high across the first ack.
    @(posedge clk);
    #1;
    bus.req_mem_access         = 1'b1;
    bus.data_inout_access_type = DiatRead;
    bus.data_inout_access_size = DiaSz8;
    bus.addr                   = 32'h0000_0103;
    bus.wr_data                = 32'd0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("b2b ack cycle %0d", k), 32'(bus.mem_ack),
                  (k == 3 || k == 7) ? 32'd1 : 32'd0);
      if (k == 3 || k == 7) begin
        checkOutput($sformatf("b2b rd_data cycle %0d", k), bus.rd_data,
                    32'h0000_00DE);
      end
    end
    bus.req_mem_access = 1'b0;
    @(negedge clk);
    checkOutput("b2b idle after drop", 32'(bus.mem_ack), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frost32_mem_bridge.md
# frost32_mem_bridge

Memory-side bridge directly downstream of the Frost32 CPU data port. It consumes the CPU's outgoing request (address, write data, access type, access size, request strobe), performs it as a sequence of byte accesses against an internal byte-wide synchronous RAM, and returns read data plus a one-cycle completion pulse. The CPU's memory-access stall state waits on that pulse.

## Interface
Parameters:
- RAM_ADDR_WIDTH, 16, byte-address bits of the backing RAM; depth = 2**RAM_ADDR_WIDTH bytes.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_mem_access  in  1  request strobe from CPU.
- data_inout_access_type  in  1  0 = read (DiatRead), 1 = write (DiatWrite).
- data_inout_access_size  in  2  0 = 32-bit, 1 = 16-bit, 2 = 8-bit, 3 = bad.
- addr  in  32  byte address.
- wr_data  in  32  write data; only low 16/8 bits used for narrow writes.
- rd_data  out  32  read result; returned to the CPU as its port-in data.
- mem_ack  out  1  one-cycle completion pulse.
- mem_err  out  1  asserted with mem_ack when the request was rejected.

## Operation
- States: StIdle, StXfer, StDrain, StAck.
- StIdle: if req_mem_access = 1, latch addr, type, size, and wr_data; clear byte counter. Bad size, or misaligned (16-bit with addr[0] = 1; 32-bit with addr[1:0] != 0): latch err = 1 and go to StAck with no RAM access. Otherwise go to StXfer.
- StXfer: issue byte access i at RAM address (addr + i) mod depth, i = 0 .. n-1, with n = 4/2/1 for 32/16/8-bit.
  - Byte order is little-endian: byte i is wr_data[8i+7:8i].
  - Writes assert RAM write-enable.
  - After byte n-1, writes go to StAck and reads go to StDrain.
- StDrain: captures the last read byte, then goes to StAck.
  - RAM read latency is 1 cycle: byte i lands in the assembly register on the cycle after it was addressed.
- StAck: mem_ack = 1 and mem_err = latched err for exactly this cycle.
  - rd_data holds the assembled word, zero-extended for 8/16-bit reads. The CPU sign-extends.
  - Next state is StIdle.
- rd_data holds its value until the next read completes. Writes and errors leave rd_data unchanged.
- Requests arriving outside StIdle are ignored. The CPU holds inputs stable until mem_ack.
- req_mem_access still high in the cycle after mem_ack is accepted as a new request.
- Address bits above RAM_ADDR_WIDTH are ignored (aliasing). Byte-address wrap from depth-1 to 0 within one access is legal.

## Timing
- Cycle A is the cycle req_mem_access is sampled high in StIdle.
- Write of n bytes: RAM writes in cycles A+1 .. A+n; mem_ack in cycle A+n+1. Latency: 32-bit = 5, 16-bit = 3, 8-bit = 2.
- Read of n bytes: addresses in A+1 .. A+n; mem_ack and valid rd_data in cycle A+n+2. Latency: 32-bit = 6, 16-bit = 4, 8-bit = 3.
- Error: mem_ack = mem_err = 1 in A+1. No RAM access occurs.
- Reset values: state StIdle, rd_data = 0, mem_ack = 0, mem_err = 0, latched registers = 0. RAM contents are not reset.
- Reset mid-operation aborts the access in the next cycle. Bytes already written stay written, and no mem_ack is produced.
- Back-to-back: a request held high through mem_ack is re-accepted at A' = ack cycle + 1.

## Structure
- Package PkgFrost32Cpu gains:
  - enum MemBridgeState (StIdle, StXfer, StDrain, StAck), width set by a new define MSB_POS__FROST32_MEM_BRIDGE_STATE.
  - function returning byte count for a DataInoutAccessSize.
- Reuse existing DataInoutAccessType and DataInoutAccessSize for decoding.
- Sub-module frost32_byte_ram: single-port, 8-bit wide, synchronous read (1 cycle), write-enable, parameter RAM_ADDR_WIDTH.

## Test plan
- Write 32-bit 0xDEADBEEF to 0x100 -> ack at A+5, err = 0. Then 32-bit read of 0x100 -> rd_data 0xDEADBEEF at A+6. 8-bit read of 0x100 -> 0x000000EF. 8-bit read of 0x103 -> 0x000000DE.
- 16-bit write of 0xAAAA_1234 to 0x202 -> bytes 0x34, 0x12 at 0x202/0x203, ack at A+3. 16-bit read -> 0x00001234 at A+4. Bytes 0x200/0x201 are unchanged.
- 32-bit read of 0x101, 16-bit read of 0x201, and size = 3 -> each gives ack and err at A+1, no RAM write, rd_data unchanged.
- Aliasing: write 8-bit 0x5A to 0x0001_0004 with RAM_ADDR_WIDTH = 16 -> 8-bit read of 0x0004 returns 0x5A.
- Assert rst in cycle A+2 of a 32-bit write of 0x11223344 to 0x300 -> no ack, state StIdle. Byte 0x300 = 0x44; bytes 0x302 and 0x303 keep their old values.
- req held high for two back-to-back 8-bit reads -> acks at A+3 and A+7, with no idle gap beyond the StIdle cycle.
